// File: rtl/adder_feed_queue.sv
// adder_feed_queue: operand FIFO feeding a registered adder.
// Buffers {a, b} pairs behind a valid/ready handshake, issues at most one
// pair per cycle onto registered operand outputs, and runs a valid bit
// through a delay line matched to the adder latency so sum_valid marks the
// cycle the adder's result belongs to a real pair.
// Optional feature macro: ADDQ_TAG_EN adds out_tag/sum_tag sequence numbers.
module adder_feed_queue #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     issue_en,
  output logic [WIDTH-1:0]         out_a,
  output logic [WIDTH-1:0]         out_b,
  output logic                     out_valid,
  output logic                     sum_valid,
  output logic [$clog2(DEPTH):0]   level
`ifdef ADDQ_TAG_EN
  ,
  output logic [7:0]               out_tag,
  output logic [7:0]               sum_tag
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic [WIDTH-1:0]   out_a_q, out_a_d;
  logic [WIDTH-1:0]   out_b_q, out_b_d;
  logic               out_valid_q, out_valid_d;
  logic [LATENCY-1:0] vpipe_q;
  logic               push;
  logic               issue;

  // Issue looks only at the registered level, so a pair pushed into an empty
  // queue waits one cycle and a full queue stays not-ready even while draining.
  assign in_ready = !reset && (level_q != FULL);
  assign push     = in_valid && in_ready;
  assign issue    = !reset && issue_en && (level_q != '0);

  // Next-state for pointers, occupancy and the operand output registers.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_valid_d = 1'b0;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (issue) begin
      {out_a_d, out_b_d} = mem_q[rd_ptr_q];
      out_valid_d        = 1'b1;
      rd_ptr_d           = rd_ptr_q + AW'(1);
    end
    case ({push, issue})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control and operand registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Pair storage; written on push only.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; level and pointers alone decide which entries are live.
    if (push) begin
      mem_q[wr_ptr_q] <= {in_a, in_b};
    end
  end

  // Valid delay line matched to the adder latency; cleared on reset so
  // in-flight results from before the reset are never flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      vpipe_q <= '0;
    end else begin
      vpipe_q[0] <= out_valid_q;
      for (int i = 1; i < LATENCY; i++) begin
        vpipe_q[i] <= vpipe_q[i-1];
      end
    end
  end

  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_valid = out_valid_q;
  assign sum_valid = vpipe_q[LATENCY-1];
  assign level     = level_q;

`ifdef ADDQ_TAG_EN
  logic [7:0] tag_cnt_q;
  logic [7:0] out_tag_q;
  logic [7:0] tpipe_q [LATENCY];

  // Issue sequence number: the first pair after reset carries tag 0; the tag
  // then follows the pair through a pipe parallel to the valid delay line.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_cnt_q <= '0;
      out_tag_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tpipe_q[i] <= '0;
      end
    end else begin
      if (issue) begin
        out_tag_q <= tag_cnt_q;
        tag_cnt_q <= tag_cnt_q + 8'd1;
      end
      tpipe_q[0] <= out_tag_q;
      for (int i = 1; i < LATENCY; i++) begin
        tpipe_q[i] <= tpipe_q[i-1];
      end
    end
  end

  assign out_tag = out_tag_q;
  assign sum_tag = tpipe_q[LATENCY-1];
`endif

endmodule

// File: tb/tb_adder_feed_queue.sv
// Directed testbench for adder_feed_queue with a small registered-adder model
// standing in for adder_reg. Tag checks compile when ADDQ_TAG_EN is defined.
module tb_adder_feed_queue;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       issue_en;
  logic [7:0] out_a;
  logic [7:0] out_b;
  logic       out_valid;
  logic       sum_valid;
  logic [3:0] level;
`ifdef ADDQ_TAG_EN
  logic [7:0] out_tag;
  logic [7:0] sum_tag;
`endif

  int total = 0;
  int bad   = 0;

  adder_feed_queue #(.WIDTH(8), .DEPTH(8), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .issue_en  (issue_en),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_valid (out_valid),
    .sum_valid (sum_valid),
    .level     (level)
`ifdef ADDQ_TAG_EN
    ,
    .out_tag   (out_tag),
    .sum_tag   (sum_tag)
`endif
  );

  always #5 clk = ~clk;

  // Registered adder model with LAT stages; s is the adder's sum output.
  logic [7:0] s_pipe [LAT];
  always @(posedge clk) begin
    s_pipe[0] <= out_a + out_b;
    for (int i = 1; i < LAT; i++) s_pipe[i] <= s_pipe[i-1];
  end
  wire [7:0] s = s_pipe[LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; issue_en = 1'b1; in_a = 8'hAA; in_b = 8'hBB;
    step(); step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++; if (out_valid !== 1'b0 || sum_valid !== 1'b0) begin bad++; $display("FAIL reset_valids got=%b%b want=00", out_valid, sum_valid); end
    total++; if (out_a !== 8'h00 || out_b !== 8'h00) begin bad++; $display("FAIL reset_operands got=%h/%h want=00/00", out_a, out_b); end
    reset = 1'b0; in_valid = 1'b0; issue_en = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; issue_en = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || level !== 4'd1) begin bad++; $display("FAIL single_no_bypass got valid=%b level=%0d want 0/1", out_valid, level); end
    step();
    total++; if (out_valid !== 1'b1 || out_a !== 8'h12 || out_b !== 8'h34) begin bad++; $display("FAIL single_issue got v=%b a=%h b=%h want 1/12/34", out_valid, out_a, out_b); end
    step();
    total++; if (out_valid !== 1'b0 || sum_valid !== 1'b0) begin bad++; $display("FAIL single_gap got v=%b sv=%b want 0/0", out_valid, sum_valid); end
    step();
    total++; if (sum_valid !== 1'b1 || s !== 8'h46) begin bad++; $display("FAIL single_sum got sv=%b s=%h want 1/46", sum_valid, s); end
    step();
    total++; if (sum_valid !== 1'b0) begin bad++; $display("FAIL single_sum_once got sv=%b want 0", sum_valid); end
    issue_en = 1'b0;
  endtask

  task automatic test_fill_drain();
    issue_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_a = 8'(i); in_b = 8'(2 * i);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready[%0d] got=%b want=1", i, in_ready); end
      step();
    end
    in_a = 8'h99; in_b = 8'h99;
    total++; if (in_ready !== 1'b0 || level !== 4'd8) begin bad++; $display("FAIL full got ready=%b level=%0d want 0/8", in_ready, level); end
    step();
    total++; if (level !== 4'd8) begin bad++; $display("FAIL ninth_push got level=%0d want 8", level); end
    in_valid = 1'b0; issue_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || out_a !== 8'(i) || out_b !== 8'(2 * i)) begin
        bad++; $display("FAIL drain[%0d] got v=%b a=%h b=%h want 1/%h/%h", i, out_valid, out_a, out_b, 8'(i), 8'(2 * i));
      end
    end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL drained_level got=%0d want 0", level); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_extra got v=%b a=%h want 0", out_valid, out_a); end
    issue_en = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_simultaneous();
    issue_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 8'(8'h10 + i); in_b = 8'h01;
      step();
    end
    total++; if (level !== 4'd3) begin bad++; $display("FAIL simul_pre_level got=%0d want 3", level); end
    in_valid = 1'b1; in_a = 8'h20; in_b = 8'h01; issue_en = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (level !== 4'd3) begin bad++; $display("FAIL simul_level got=%0d want 3", level); end
    total++; if (out_valid !== 1'b1 || out_a !== 8'h10) begin bad++; $display("FAIL simul_oldest got v=%b a=%h want 1/10", out_valid, out_a); end
    step();
    total++; if (out_a !== 8'h11 || level !== 4'd2) begin bad++; $display("FAIL simul_2nd got a=%h level=%0d want 11/2", out_a, level); end
    step();
    total++; if (out_a !== 8'h12) begin bad++; $display("FAIL simul_3rd got a=%h want 12", out_a); end
    step();
    total++; if (out_valid !== 1'b1 || out_a !== 8'h20 || level !== 4'd0) begin bad++; $display("FAIL simul_4th got v=%b a=%h level=%0d want 1/20/0", out_valid, out_a, level); end
    issue_en = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_wrap();
    int pi = 0, no = 0, ns = 0, cyc = 0;
    logic did;
    while ((no < 20 || ns < 20) && cyc < 200) begin
      issue_en = (cyc % 2) == 1;
      in_valid = (pi < 20); in_a = 8'(pi); in_b = 8'(255 - pi);
      #1;
      did = in_valid && in_ready;
      step();
      if (did) pi++;
      if (out_valid) begin
        total++;
        if (out_a !== 8'(no) || out_b !== 8'(255 - no)) begin
          bad++; $display("FAIL wrap_order[%0d] got a=%h b=%h want %h/%h", no, out_a, out_b, 8'(no), 8'(255 - no));
        end
        no++;
      end
      if (sum_valid) begin
        total++;
        if (s !== 8'hFF) begin bad++; $display("FAIL wrap_sum[%0d] got s=%h want ff", ns, s); end
        ns++;
      end
      cyc++;
    end
    in_valid = 1'b0; issue_en = 1'b0;
    total++; if (no != 20 || ns != 20) begin bad++; $display("FAIL wrap_count got out=%0d sum=%0d want 20/20", no, ns); end
  endtask

  task automatic test_mid_reset();
    int seen = 0;
    issue_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_a = 8'(8'hA0 + i); in_b = 8'h01;
      step();
    end
    in_valid = 1'b0; issue_en = 1'b1;
    step(); step();
    total++; if (level !== 4'd5 || out_a !== 8'hA1) begin bad++; $display("FAIL mid_pre got level=%0d a=%h want 5/a1", level, out_a); end
    reset = 1'b1; in_valid = 1'b1; in_a = 8'hEE;
    step();
    total++; if (out_valid !== 1'b0 || sum_valid !== 1'b0 || level !== 4'd0) begin bad++; $display("FAIL mid_reset got v=%b sv=%b level=%0d want 0/0/0", out_valid, sum_valid, level); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_ready got=%b want 0", in_ready); end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_after_ready got=%b want 1", in_ready); end
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid !== 1'b0 || sum_valid !== 1'b0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_ghost got=%0d stale cycles want 0", seen); end
    in_valid = 1'b1; in_a = 8'h55; in_b = 8'h01;
    step();
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b1 || out_a !== 8'h55) begin bad++; $display("FAIL mid_fresh got v=%b a=%h want 1/55", out_valid, out_a); end
    issue_en = 1'b0;
    step(); step(); step();
  endtask

`ifdef ADDQ_TAG_EN
  task automatic test_tag();
    int pi = 0, no = 0, ns = 0, cyc = 0;
    logic [7:0] tq [$];
    logic [7:0] want;
    reset = 1'b1; step(); reset = 1'b0;
    total++; if (out_tag !== 8'd0 || sum_tag !== 8'd0) begin bad++; $display("FAIL tag_reset got %h/%h want 00/00", out_tag, sum_tag); end
    issue_en = 1'b1;
    while ((no < 260 || ns < 260) && cyc < 600) begin
      in_valid = (pi < 260); in_a = 8'(pi); in_b = 8'h00;
      step();
      if (in_valid) pi++;
      if (out_valid) begin
        total++;
        if (out_tag !== 8'(no)) begin bad++; $display("FAIL out_tag[%0d] got=%h want=%h", no, out_tag, 8'(no)); end
        tq.push_back(out_tag);
        no++;
      end
      if (sum_valid) begin
        want = (tq.size() > 0) ? tq.pop_front() : 8'hxx;
        total++;
        if (sum_tag !== want) begin bad++; $display("FAIL sum_tag[%0d] got=%h want=%h", ns, sum_tag, want); end
        ns++;
      end
      cyc++;
    end
    in_valid = 1'b0; issue_en = 1'b0;
    total++; if (no != 260 || ns != 260) begin bad++; $display("FAIL tag_count got out=%0d sum=%0d want 260/260", no, ns); end
  endtask
`endif

  initial begin
    reset = 1'b1; in_valid = 1'b0; issue_en = 1'b0; in_a = '0; in_b = '0;
    test_reset();
    test_single();
    test_fill_drain();
    test_simultaneous();
    test_wrap();
    test_mid_reset();
`ifdef ADDQ_TAG_EN
    test_tag();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_feed_queue.md
# adder_feed_queue

Operand queue directly upstream of the registered adder (`adder_reg`). It buffers {a, b} operand pairs from a producer using a valid/ready handshake and issues one pair per cycle onto registered operand outputs that drive the adder. It carries a valid bit through a delay line matched to the adder's latency, so downstream logic knows exactly which cycle the adder's `s`/`cout` hold a real result.

## Interface
Parameters:
- `WIDTH`, 8: operand width; matches the adder width.
- `DEPTH`, 8: queue entries; power of two, at least 2.
- `LATENCY`, 2: adder cycles from operand input to valid `s`; at least 1.

Ports:
- `clk`, input, 1: the single clock; all logic is rising-edge.
- `reset`, input, 1: synchronous, active-high.
- `in_valid`, input, 1: producer presents a pair.
- `in_ready`, output, 1: queue accepts a pair this cycle.
- `in_a`, input, WIDTH: operand a.
- `in_b`, input, WIDTH: operand b.
- `issue_en`, input, 1: consumer permits an issue this cycle.
- `out_a`, output, WIDTH: registered operand a; connects to the adder's `a`.
- `out_b`, output, WIDTH: registered operand b; connects to the adder's `b`.
- `out_valid`, output, 1: `out_a`/`out_b` hold a newly issued pair this cycle.
- `sum_valid`, output, 1: the adder's `s`/`cout` hold the result of a valid pair.
- `level`, output, clog2(DEPTH)+1: current occupancy.

## Operation
- Storage is DEPTH entries of {a, b}.
  - `wr_ptr` and `rd_ptr` are clog2(DEPTH) bits and wrap naturally.
  - `level` is clog2(DEPTH)+1 bits.
- `in_ready` = !reset && (level != DEPTH). It is combinational from registered state.
- **Push:** occurs when `in_valid && in_ready`. The pair is written at `wr_ptr`, and `wr_ptr` increments.
- **Issue:** occurs when `issue_en && level != 0`.
  - On the edge: `out_a`/`out_b` <= head entry, `out_valid` <= 1, and `rd_ptr` increments.
  - With no issue: `out_valid` <= 0 and `out_a`/`out_b` hold their last values.
- **Level update:**
  - Push only: +1.
  - Issue only: -1.
  - Both: unchanged.
- **No bypass:** an issue decision uses the registered `level`.
  - A push into an empty queue cannot issue in the same cycle.
  - At full, `in_ready` = 0 even if an issue happens in that cycle.
- **Valid delay line:** a LATENCY-bit shift register `vpipe` is fed by `out_valid`; `sum_valid` = `vpipe[LATENCY-1]`.
- **Ordering:** strictly FIFO. No pair is dropped or duplicated.
- **Ignored inputs:** while `reset` is high, `in_valid` and `issue_en` are ignored.

## Timing
- **Reset values:** `level`=0, pointers 0, `out_a`/`out_b`=0, `out_valid`=0, `vpipe`=0, `sum_valid`=0, `in_ready`=0 while `reset` is high.
- **First cycle after reset:** `in_ready`=1.
- **Push to `out_valid`:** a push at edge k into an empty queue with `issue_en` held high gives `out_valid` high after edge k+1.
- **`out_valid` to `sum_valid`:** `sum_valid` rises exactly LATENCY cycles after `out_valid`, one cycle per issued pair.
- **Throughput:** one push and one issue per cycle sustained.
- **Reset mid-operation:** all queued entries and in-flight `vpipe` bits are discarded on that edge. No pre-reset pair ever produces `out_valid` or `sum_valid` afterwards.

## Configuration
- Macro: `ADDQ_TAG_EN`.
- **Defined:**
  - Adds output `out_tag` [7:0] and output `sum_tag` [7:0].
  - `out_tag` is an 8-bit issue sequence number. It is 0 after reset, increments by one on each issue, wraps 255 to 0, and updates alongside `out_a`.
  - `sum_tag` is `out_tag` delayed by LATENCY cycles through a tag pipe parallel to `vpipe`.
  - Both tags reset to 0.
- **Undefined:** both ports and all tag logic are absent. All other behaviour is identical.

## Test plan
- **Single pair:** after reset, push a=8'h12, b=8'h34 with `issue_en`=1.
  - Next cycle: `out_valid`=1, `out_a`=12, `out_b`=34.
  - Two cycles later: `sum_valid`=1 and the adder's `s`=8'h46.
- **Fill and drain:** `issue_en`=0, push 8 pairs (a=i, b=2i).
  - `in_ready` drops after the 8th push, `level`=8, and a 9th push is ignored.
  - Set `issue_en`=1: 8 consecutive `out_valid` cycles with a=0..7 in order, then `level`=0.
- **Simultaneous push and issue:** at `level`=3, push and issue in the same cycle.
  - `level` stays 3.
  - The issued pair is the oldest; the new pair emerges 4th.
- **Wrap-around:** stream 20 pairs (a=i, b=8'hFF-i) while `issue_en` toggles every cycle.
  - Output order matches input order and pointers wrap twice.
  - `s`=8'hFF on every `sum_valid`.
- **Mid-stream reset:** assert `reset` for 1 cycle with 5 pairs queued and 2 in flight.
  - Next cycle: `out_valid`, `sum_valid` and `level` are all 0; `in_ready`=1 after `reset` falls.
  - No old pair reappears.
- **With `ADDQ_TAG_EN`:** issue 260 pairs.
  - `out_tag` runs 0..255, 0..3.
  - `sum_tag` equals `out_tag` from LATENCY cycles earlier on every `sum_valid`.
